// File: rtl/axi_mem_slv.sv
// -----------------------------------------------------------------------------
// axi_mem_slv -- AXI4 responder backed by an on-chip word-addressed memory.
//
// Terminates one crossbar master port as a scratchpad / boot RAM. The write
// and read paths are independent FSMs, so one write burst and one read burst
// may be in flight together. Out-of-window beats and unsupported bursts are
// answered with SLVERR so the requester is never stalled.
//
// Optional feature macro: AXI_MEM_SLV_WRAP_EN
//   defined   -> WRAP bursts with len 1/3/7/15 are served with wrap addressing
//   undefined -> every WRAP burst is an error burst (no wrap logic built)
//
// Ports:
//   clk_i       in   clock
//   rst_i       in   synchronous active-high reset
//   slv_req_i   in   AXI request  (aw/w/b_ready/ar/r_ready)
//   slv_resp_o  out  AXI response (aw_ready/w_ready/b/ar_ready/r)
//
// The package below provides default request/response structs matching the
// default parameters (64-bit address and data, 1-bit id/user fields).
// -----------------------------------------------------------------------------
package axi_mem_slv_pkg;

   typedef struct packed {
      logic [0:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [5:0]  atop;
      logic [0:0]  user;
   } aw_chan_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  strb;
      logic        last;
      logic [0:0]  user;
   } w_chan_t;

   typedef struct packed {
      logic [0:0]  id;
      logic [1:0]  resp;
      logic [0:0]  user;
   } b_chan_t;

   typedef struct packed {
      logic [0:0]  id;
      logic [63:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [0:0]  user;
   } ar_chan_t;

   typedef struct packed {
      logic [0:0]  id;
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [0:0]  user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic     aw_ready;
      logic     ar_ready;
      logic     w_ready;
      logic     b_valid;
      b_chan_t  b;
      logic     r_valid;
      r_chan_t  r;
   } axi_rsp_t;

endpackage

module axi_mem_slv #(
   parameter int unsigned          IdWidth   = 0,
   parameter int unsigned          AddrWidth = 64,
   parameter int unsigned          DataWidth = 64,
   parameter int unsigned          NumWords  = 1024,
   parameter logic [AddrWidth-1:0] BaseAddr  = '0,
   parameter type                  axi_req_t = axi_mem_slv_pkg::axi_req_t,
   parameter type                  axi_rsp_t = axi_mem_slv_pkg::axi_rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  axi_req_t slv_req_i,
   output axi_rsp_t slv_resp_o
);

   localparam int unsigned Bytes  = DataWidth / 8;
   localparam int unsigned OffW   = $clog2(Bytes);
   localparam int unsigned IdxW   = (NumWords > 1) ? $clog2(NumWords) : 1;
   localparam int unsigned IdBits = (IdWidth == 0) ? 1 : IdWidth;
   localparam logic [AddrWidth-1:0] WinBytes = AddrWidth'(NumWords) << OffW;

   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstWrap  = 2'b10;
   localparam logic [1:0] BurstRsvd  = 2'b11;
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

`ifdef AXI_MEM_SLV_WRAP_EN
   localparam bit WrapEn = 1'b1;
`else
   localparam bit WrapEn = 1'b0;
`endif

   // Unsigned offset from the window base; addresses below the base wrap
   // around to huge values, so one compare covers both window edges.
   function automatic logic in_range(input logic [AddrWidth-1:0] addr);
      return (addr - BaseAddr) < WinBytes;
   endfunction

   function automatic logic [IdxW-1:0] word_idx(input logic [AddrWidth-1:0] addr);
      return IdxW'((addr - BaseAddr) >> OffW);
   endfunction

   // Whole-burst error: wrong beat size, reserved burst type, or a WRAP burst
   // that cannot be served in this build / with this length.
   function automatic logic ax_err(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [7:0] len);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (size != 3'(OffW)) || (burst == BurstRsvd) ||
             ((burst == BurstWrap) && !(WrapEn && wrap_len_ok));
   endfunction

   function automatic logic [AddrWidth-1:0] incr_addr(input logic [AddrWidth-1:0] addr,
                                                      input logic [1:0] burst);
      return (burst == BurstFixed) ? addr : addr + AddrWidth'(Bytes);
   endfunction

`ifdef AXI_MEM_SLV_WRAP_EN
   // Increment inside a (len+1)*Bytes container aligned to its own size.
   function automatic logic [AddrWidth-1:0] wrap_addr(input logic [AddrWidth-1:0] addr,
                                                      input logic [7:0] len);
      logic [AddrWidth-1:0] mask;
      mask = ((AddrWidth'(len) + AddrWidth'(1)) << OffW) - AddrWidth'(1);
      return (addr & ~mask) | ((addr + AddrWidth'(Bytes)) & mask);
   endfunction
`endif

   logic [DataWidth-1:0] mem_q [NumWords];

   // ---------------------------------------------------------------- write path
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

   w_state_e             w_state_q, w_state_d;
   logic [IdBits-1:0]    aw_id_q, aw_id_d;
   logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
   logic [7:0]           aw_len_q, aw_len_d;
   logic [1:0]           aw_burst_q, aw_burst_d;
   logic                 aw_err_q, aw_err_d;
   logic                 b_err_q, b_err_d;
   logic                 w_beat_ok;
   logic                 mem_we;

   // NOTE: every signal driven here gets a default first, otherwise an
   // unassigned branch would infer a latch.
   always_comb begin
      w_state_d  = w_state_q;
      aw_id_d    = aw_id_q;
      aw_addr_d  = aw_addr_q;
      aw_len_d   = aw_len_q;
      aw_burst_d = aw_burst_q;
      aw_err_d   = aw_err_q;
      b_err_d    = b_err_q;
      mem_we     = 1'b0;
      w_beat_ok  = !aw_err_q && in_range(aw_addr_q);
      case (w_state_q)
         W_IDLE: begin
            if (slv_req_i.aw_valid) begin
               aw_id_d    = slv_req_i.aw.id;
               aw_addr_d  = slv_req_i.aw.addr;
               aw_len_d   = slv_req_i.aw.len;
               aw_burst_d = slv_req_i.aw.burst;
               aw_err_d   = ax_err(slv_req_i.aw.size, slv_req_i.aw.burst, slv_req_i.aw.len);
               b_err_d    = 1'b0;
               w_state_d  = W_DATA;
            end
         end
         W_DATA: begin
            if (slv_req_i.w_valid) begin
               mem_we    = w_beat_ok;
               b_err_d   = b_err_q | !w_beat_ok;
               aw_addr_d = incr_addr(aw_addr_q, aw_burst_q);
`ifdef AXI_MEM_SLV_WRAP_EN
               if (aw_burst_q == BurstWrap) aw_addr_d = wrap_addr(aw_addr_q, aw_len_q);
`endif
               // w.last is trusted; the beat count is never checked against len.
               if (slv_req_i.w.last) w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (slv_req_i.b_ready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state_q  <= W_IDLE;
         aw_id_q    <= '0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_burst_q <= '0;
         aw_err_q   <= 1'b0;
         b_err_q    <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         aw_id_q    <= aw_id_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         aw_burst_q <= aw_burst_d;
         aw_err_q   <= aw_err_d;
         b_err_q    <= b_err_d;
      end
   end

   // NOTE: the array is deliberately not reset; contents survive rst_i and
   // a reset port would block mapping onto RAM macros.
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) begin
         for (int unsigned b = 0; b < Bytes; b++) begin
            if (slv_req_i.w.strb[b]) begin
               mem_q[word_idx(aw_addr_q)][8*b +: 8] <= slv_req_i.w.data[8*b +: 8];
            end
         end
      end
   end

   // ----------------------------------------------------------------- read path
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   r_state_e             r_state_q, r_state_d;
   logic [IdBits-1:0]    ar_id_q, ar_id_d;
   logic [AddrWidth-1:0] ar_addr_q, ar_addr_d;   // address of the next beat
   logic [7:0]           ar_len_q, ar_len_d;
   logic [1:0]           ar_burst_q, ar_burst_d;
   logic                 ar_err_q, ar_err_d;
   logic [7:0]           r_cnt_q, r_cnt_d;
   logic [DataWidth-1:0] r_data_q, r_data_d;
   logic [1:0]           r_resp_q, r_resp_d;
   logic                 rd_load, rd_err, rd_ok;
   logic [AddrWidth-1:0] rd_addr;
   logic [1:0]           rd_burst;
   logic [7:0]           rd_len;

   always_comb begin
      r_state_d  = r_state_q;
      ar_id_d    = ar_id_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      ar_burst_d = ar_burst_q;
      ar_err_d   = ar_err_q;
      r_cnt_d    = r_cnt_q;
      r_data_d   = r_data_q;
      r_resp_d   = r_resp_q;
      rd_load    = 1'b0;
      rd_addr    = ar_addr_q;
      rd_burst   = ar_burst_q;
      rd_len     = ar_len_q;
      rd_err     = ar_err_q;
      rd_ok      = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (slv_req_i.ar_valid) begin
               ar_id_d    = slv_req_i.ar.id;
               ar_len_d   = slv_req_i.ar.len;
               ar_burst_d = slv_req_i.ar.burst;
               ar_err_d   = ax_err(slv_req_i.ar.size, slv_req_i.ar.burst, slv_req_i.ar.len);
               rd_addr    = slv_req_i.ar.addr;
               rd_burst   = slv_req_i.ar.burst;
               rd_len     = slv_req_i.ar.len;
               rd_err     = ar_err_d;
               rd_load    = 1'b1;
               r_cnt_d    = '0;
               r_state_d  = R_DATA;
            end
         end
         R_DATA: begin
            if (slv_req_i.r_ready) begin
               if (r_cnt_q == ar_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  rd_load = 1'b1;
                  r_cnt_d = r_cnt_q + 8'd1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      // The array is read combinationally ahead of the edge, so a write to
      // the same word on that edge is not yet visible: pre-write data wins.
      if (rd_load) begin
         rd_ok     = !rd_err && in_range(rd_addr);
         r_data_d  = rd_ok ? mem_q[word_idx(rd_addr)] : '0;
         r_resp_d  = rd_ok ? RespOkay : RespSlvErr;
         ar_addr_d = incr_addr(rd_addr, rd_burst);
`ifdef AXI_MEM_SLV_WRAP_EN
         if (rd_burst == BurstWrap) ar_addr_d = wrap_addr(rd_addr, rd_len);
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state_q  <= R_IDLE;
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_burst_q <= '0;
         ar_err_q   <= 1'b0;
         r_cnt_q    <= '0;
         r_data_q   <= '0;
         r_resp_q   <= '0;
      end else begin
         r_state_q  <= r_state_d;
         ar_id_q    <= ar_id_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         ar_burst_q <= ar_burst_d;
         ar_err_q   <= ar_err_d;
         r_cnt_q    <= r_cnt_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
      end
   end

   // -------------------------------------------------------------- response
   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = (w_state_q == W_IDLE);
      slv_resp_o.w_ready  = (w_state_q == W_DATA);
      slv_resp_o.b_valid  = (w_state_q == W_RESP);
      slv_resp_o.b.id     = aw_id_q;
      slv_resp_o.b.resp   = b_err_q ? RespSlvErr : RespOkay;
      slv_resp_o.ar_ready = (r_state_q == R_IDLE);
      slv_resp_o.r_valid  = (r_state_q == R_DATA);
      slv_resp_o.r.id     = ar_id_q;
      slv_resp_o.r.data   = r_data_q;
      slv_resp_o.r.resp   = r_resp_q;
      slv_resp_o.r.last   = (r_state_q == R_DATA) && (r_cnt_q == ar_len_q);
   end

   // Cache/prot/qos/lock/region/atop/user are intentionally ignored; the
   // write len only matters when wrap addressing is built.
   logic unused_in;
`ifdef AXI_MEM_SLV_WRAP_EN
   assign unused_in = ^slv_req_i;
`else
   assign unused_in = ^{slv_req_i, aw_len_q};
`endif

endmodule

// File: tb/tb_axi_mem_slv.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_slv -- directed self-checking bench for axi_mem_slv.
// DataWidth=64, BaseAddr=0x1000, NumWords=1024 (window 0x1000..0x2FFF).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axi_mem_slv;
   import axi_mem_slv_pkg::*;

   localparam int Budget = 50;
   localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

   logic     clk;
   logic     rst;
   axi_req_t req;
   axi_rsp_t rsp;

   int n_checks = 0;
   int n_fail   = 0;

   axi_mem_slv #(
      .BaseAddr (64'h1000)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .slv_req_i  (req),
      .slv_resp_o (rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_aw(input logic [63:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] size);
      int n = 0;
      req.aw       = '0;
      req.aw.addr  = addr;
      req.aw.len   = len;
      req.aw.burst = burst;
      req.aw.size  = size;
      req.aw_valid = 1'b1;
      while (!rsp.aw_ready && n < Budget) begin @(negedge clk); n++; end
      check("aw_handshake", rsp.aw_ready, 1);
      @(negedge clk);
      req.aw_valid = 1'b0;
   endtask

   task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int n = 0;
      req.w.data  = data;
      req.w.strb  = strb;
      req.w.last  = last;
      req.w_valid = 1'b1;
      while (!rsp.w_ready && n < Budget) begin @(negedge clk); n++; end
      check("w_handshake", rsp.w_ready, 1);
      @(negedge clk);
      req.w_valid = 1'b0;
   endtask

   task automatic b_wait(input logic [1:0] resp, input string tag);
      int n = 0;
      req.b_ready = 1'b1;
      while (!rsp.b_valid && n < Budget) begin @(negedge clk); n++; end
      check({tag, "_bvalid"}, rsp.b_valid, 1);
      check({tag, "_bresp"}, rsp.b.resp, resp);
      @(negedge clk);
      req.b_ready = 1'b0;
   endtask

   task automatic do_ar(input logic [63:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] size);
      int n = 0;
      req.ar       = '0;
      req.ar.addr  = addr;
      req.ar.len   = len;
      req.ar.burst = burst;
      req.ar.size  = size;
      req.ar_valid = 1'b1;
      while (!rsp.ar_ready && n < Budget) begin @(negedge clk); n++; end
      check("ar_handshake", rsp.ar_ready, 1);
      @(negedge clk);
      req.ar_valid = 1'b0;
   endtask

   task automatic r_beat(input logic [63:0] data, input logic [1:0] resp,
                         input logic last, input string tag);
      int n = 0;
      req.r_ready = 1'b1;
      while (!rsp.r_valid && n < Budget) begin @(negedge clk); n++; end
      check({tag, "_rvalid"}, rsp.r_valid, 1);
      check({tag, "_rdata"}, rsp.r.data, data);
      check({tag, "_rresp"}, rsp.r.resp, resp);
      check({tag, "_rlast"}, rsp.r.last, last);
      @(negedge clk);
      req.r_ready = 1'b0;
   endtask

   task automatic write_word(input logic [63:0] addr, input logic [63:0] data,
                             input logic [7:0] strb);
      do_aw(addr, 8'd0, INCR, 3'd3);
      w_beat(data, strb, 1'b1);
      b_wait(OKAY, "wr");
   endtask

   task automatic read_word(input logic [63:0] addr, input logic [63:0] data, input string tag);
      do_ar(addr, 8'd0, INCR, 3'd3);
      r_beat(data, OKAY, 1'b1, tag);
   endtask

   // Hard stop in case a handshake never resolves within the task budgets.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      req = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset values
      check("rst_aw_ready", rsp.aw_ready, 1);
      check("rst_ar_ready", rsp.ar_ready, 1);
      check("rst_w_ready", rsp.w_ready, 0);
      check("rst_b_valid", rsp.b_valid, 0);
      check("rst_r_valid", rsp.r_valid, 0);
      check("rst_r_last", rsp.r.last, 0);
      check("rst_b_resp", rsp.b.resp, 0);
      check("rst_r_data", rsp.r.data, 0);

      // W before AW is held off
      req.w_valid = 1'b1;
      req.w.data  = 64'hDEAD;
      req.w.strb  = 8'hFF;
      @(negedge clk);
      check("w_before_aw", rsp.w_ready, 0);
      req.w_valid = 1'b0;

      // INCR write of 4 beats, then read back
      do_aw(64'h1000, 8'd3, INCR, 3'd3);
      check("w_ready_after_aw", rsp.w_ready, 1);
      for (int i = 0; i < 4; i++) w_beat(64'hA0 + 64'(i), 8'hFF, i == 3);
      check("b_latency", rsp.b_valid, 1);
      b_wait(OKAY, "incr");
      do_ar(64'h1000, 8'd3, INCR, 3'd3);
      check("r_latency", rsp.r_valid, 1);
      for (int i = 0; i < 4; i++) r_beat(64'hA0 + 64'(i), OKAY, i == 3, "incr");
      check("ar_ready_after_last", rsp.ar_ready, 1);

      // Strobe merge
      write_word(64'h1020, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      write_word(64'h1020, 64'h0, 8'h0F);
      read_word(64'h1020, 64'hFFFF_FFFF_0000_0000, "strb");

      // Out of range: first address past the window
      do_aw(64'h3000, 8'd1, INCR, 3'd3);
      w_beat(64'hDEAD, 8'hFF, 1'b0);
      w_beat(64'hBEEF, 8'hFF, 1'b1);
      b_wait(SLVERR, "oor");
      read_word(64'h1000, 64'hA0, "oor_base");
      do_ar(64'h3000, 8'd1, INCR, 3'd3);
      r_beat(64'h0, SLVERR, 1'b0, "oor0");
      r_beat(64'h0, SLVERR, 1'b1, "oor1");
      do_ar(64'h0FF8, 8'd0, INCR, 3'd3);
      r_beat(64'h0, SLVERR, 1'b1, "below");

      // Wrong size: write dropped, SLVERR
      do_aw(64'h1008, 8'd0, INCR, 3'd2);
      w_beat(64'h1234, 8'hFF, 1'b1);
      b_wait(SLVERR, "size");
      read_word(64'h1008, 64'hA1, "size_kept");

      // Reserved burst type
      do_ar(64'h1000, 8'd0, RSVD, 3'd3);
      r_beat(64'h0, SLVERR, 1'b1, "rsvd");

      // Backpressure: first beat held while both words are rewritten
      write_word(64'h1040, 64'h11, 8'hFF);
      write_word(64'h1048, 64'h22, 8'hFF);
      do_ar(64'h1040, 8'd1, INCR, 3'd3);
      check("bp_hold0", rsp.r.data, 64'h11);
      do_aw(64'h1040, 8'd1, INCR, 3'd3);
      w_beat(64'h99, 8'hFF, 1'b0);
      check("bp_hold1", rsp.r.data, 64'h11);
      w_beat(64'h55, 8'hFF, 1'b1);
      b_wait(OKAY, "bp_wr");
      @(negedge clk);
      check("bp_valid_held", rsp.r_valid, 1);
      check("bp_hold2", rsp.r.data, 64'h11);
      r_beat(64'h11, OKAY, 1'b0, "bp0");
      r_beat(64'h55, OKAY, 1'b1, "bp1");
      read_word(64'h1040, 64'h99, "bp_word0");

      // FIXED burst keeps hitting one word
      write_word(64'h1068, 64'h77, 8'hFF);
      do_aw(64'h1060, 8'd1, FIXED, 3'd3);
      w_beat(64'h1, 8'hFF, 1'b0);
      w_beat(64'h2, 8'hFF, 1'b1);
      b_wait(OKAY, "fixed");
      do_ar(64'h1060, 8'd1, INCR, 3'd3);
      r_beat(64'h2, OKAY, 1'b0, "fixed0");
      r_beat(64'h77, OKAY, 1'b1, "fixed1");

      // WRAP read starting mid-container (0x1010, 0x1018, 0x1000, 0x1008)
      do_ar(64'h1010, 8'd3, WRAP, 3'd3);
`ifdef AXI_MEM_SLV_WRAP_EN
      r_beat(64'hA2, OKAY, 1'b0, "wrap0");
      r_beat(64'hA3, OKAY, 1'b0, "wrap1");
      r_beat(64'hA0, OKAY, 1'b0, "wrap2");
      r_beat(64'hA1, OKAY, 1'b1, "wrap3");
`else
      for (int i = 0; i < 4; i++) r_beat(64'h0, SLVERR, i == 3, "wrap_err");
`endif

      // Reset mid-burst after 2 of 4 beats
      do_aw(64'h1080, 8'd3, INCR, 3'd3);
      w_beat(64'hB0, 8'hFF, 1'b0);
      w_beat(64'hB1, 8'hFF, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_aw_ready", rsp.aw_ready, 1);
      check("mid_rst_w_ready", rsp.w_ready, 0);
      check("mid_rst_b_valid", rsp.b_valid, 0);
      req.b_ready = 1'b1;
      @(negedge clk);
      check("mid_rst_no_b", rsp.b_valid, 0);
      req.b_ready = 1'b0;
      do_ar(64'h1080, 8'd1, INCR, 3'd3);
      r_beat(64'hB0, OKAY, 1'b0, "rst_kept0");
      r_beat(64'hB1, OKAY, 1'b1, "rst_kept1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
